// File: rtl/disp_hex_mux_ctrl.sv
// disp_hex_mux_ctrl: four-digit, common-anode seven-segment scan controller.
// Input values are captured into a shadow set on 'load' and copied into the
// active set only at a frame boundary, so a single frame never mixes two
// loads. The digits are scanned round-robin through one shared decoder. A
// guard interval at the start of each slot keeps all anodes off. All pins
// are registered.
module disp_hex_mux_ctrl #(
   parameter int N     = 18,
   parameter int GUARD = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] hex_in,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  blank_in,
   input  logic        lz_en,
   output logic [3:0]  an,
   output logic [7:0]  sseg,
   output logic        frame_tick
);

   localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};
   localparam logic [N-3:0] GUARD_V = GUARD[N-3:0];

   // Refresh counter
   logic [N-1:0] q_q, q_d;

   // Shadow set, written by load
   logic [15:0] sh_hex_q, sh_hex_d;
   logic [3:0]  sh_dp_q, sh_dp_d;
   logic [3:0]  sh_blank_q, sh_blank_d;
   logic        sh_lz_q, sh_lz_d;
   logic        pend_q, pend_d;

   // Active set, the values the scan displays
   logic [15:0] act_hex_q, act_hex_d;
   logic [3:0]  act_dp_q, act_dp_d;
   logic [3:0]  act_blank_q, act_blank_d;
   logic        act_lz_q, act_lz_d;

   // Registered pins
   logic [3:0]  an_q, an_d;
   logic [7:0]  sseg_q, sseg_d;
   logic        tick_q, tick_d;

   // Scan helpers
   logic        wrap;
   logic [1:0]  slot;
   logic [3:0]  nib;
   logic [3:0]  nib_zero;
   logic        lz_blank;
   logic        dig_blank;

   // Shared hex decoder; returns active-low {a,b,c,d,e,f,g}
   function automatic logic [6:0] hex_to_sseg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         default: s = 7'b0111000;
      endcase
      return s;
   endfunction

   // Next-state logic: counter, shadow capture, frame commit, digit decode
   always_comb begin
      q_d         = q_q + CNT_ONE;
      wrap        = (q_q == '0);

      sh_hex_d    = sh_hex_q;
      sh_dp_d     = sh_dp_q;
      sh_blank_d  = sh_blank_q;
      sh_lz_d     = sh_lz_q;
      if (load) begin
         sh_hex_d   = hex_in;
         sh_dp_d    = dp_in;
         sh_blank_d = blank_in;
         sh_lz_d    = lz_en;
      end

      // A load on the boundary cycle stays pending for the next frame
      pend_d      = load ? 1'b1 : (wrap ? 1'b0 : pend_q);

      act_hex_d   = act_hex_q;
      act_dp_d    = act_dp_q;
      act_blank_d = act_blank_q;
      act_lz_d    = act_lz_q;
      if (wrap && pend_q) begin
         act_hex_d   = sh_hex_q;
         act_dp_d    = sh_dp_q;
         act_blank_d = sh_blank_q;
         act_lz_d    = sh_lz_q;
      end

      slot     = q_q[N-1:N-2];
      nib      = act_hex_q[{slot, 2'b00} +: 4];
      nib_zero = {act_hex_q[15:12] == 4'h0, act_hex_q[11:8] == 4'h0,
                  act_hex_q[7:4]   == 4'h0, act_hex_q[3:0]  == 4'h0};
      // Digit s is a leading zero when every nibble from s up to 3 is zero
      case (slot)
         2'd3:    lz_blank = act_lz_q & nib_zero[3];
         2'd2:    lz_blank = act_lz_q & (&nib_zero[3:2]);
         2'd1:    lz_blank = act_lz_q & (&nib_zero[3:1]);
         default: lz_blank = 1'b0;
      endcase
      dig_blank = act_blank_q[slot] | lz_blank;

      an_d   = 4'b1111;
      sseg_d = 8'hFF;
      if (q_q[N-3:0] >= GUARD_V) begin
         an_d = ~(4'b0001 << slot);
         if (!dig_blank) begin
            sseg_d = {~act_dp_q[slot], hex_to_sseg(nib)};
         end
      end
      tick_d = wrap;
   end

   // State and pin registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         q_q         <= '0;
         sh_hex_q    <= 16'h0000;
         sh_dp_q     <= 4'h0;
         sh_blank_q  <= 4'hF;
         sh_lz_q     <= 1'b0;
         pend_q      <= 1'b0;
         act_hex_q   <= 16'h0000;
         act_dp_q    <= 4'h0;
         act_blank_q <= 4'hF;
         act_lz_q    <= 1'b0;
         an_q        <= 4'b1111;
         sseg_q      <= 8'hFF;
         tick_q      <= 1'b0;
      end else begin
         q_q         <= q_d;
         sh_hex_q    <= sh_hex_d;
         sh_dp_q     <= sh_dp_d;
         sh_blank_q  <= sh_blank_d;
         sh_lz_q     <= sh_lz_d;
         pend_q      <= pend_d;
         act_hex_q   <= act_hex_d;
         act_dp_q    <= act_dp_d;
         act_blank_q <= act_blank_d;
         act_lz_q    <= act_lz_d;
         an_q        <= an_d;
         sseg_q      <= sseg_d;
         tick_q      <= tick_d;
      end
   end

   assign an         = an_q;
   assign sseg       = sseg_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_disp_hex_mux_ctrl.sv
// tb_disp_hex_mux_ctrl: directed bench for disp_hex_mux_ctrl, N=4, GUARD=1.
// Sixteen-cycle frames, four-cycle slots, one dark guard cycle per slot.
module tb_disp_hex_mux_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic [15:0] hex_in = 16'h0000;
   logic [3:0]  dp_in = 4'h0;
   logic [3:0]  blank_in = 4'h0;
   logic        lz_en = 1'b0;
   logic [3:0]  an;
   logic [7:0]  sseg;
   logic        frame_tick;

   int tests = 0;
   int fails = 0;

   disp_hex_mux_ctrl #(.N(4), .GUARD(1)) dut (
      .clk(clk), .reset(reset), .load(load), .hex_in(hex_in),
      .dp_in(dp_in), .blank_in(blank_in), .lz_en(lz_en),
      .an(an), .sseg(sseg), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   // Expected {an, sseg} for display position k of a frame, given the
   // hand-computed segment byte of each digit.
   function automatic logic [11:0] exp_pins(int k, logic [7:0] e3, logic [7:0] e2,
                                            logic [7:0] e1, logic [7:0] e0);
      logic [7:0] e;
      if ((k % 4) == 0) return {4'b1111, 8'hFF};
      case (k / 4)
         3:       e = e3;
         2:       e = e2;
         1:       e = e1;
         default: e = e0;
      endcase
      return {~(4'b0001 << (k / 4)), e};
   endfunction

   // Wait (bounded) until the sample showing position 0 of a frame
   task automatic sync_frame(input string name);
      bit found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (frame_tick === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      tests++;
      if (!found) begin
         fails++;
         $display("FAIL %s: frame_tick not seen within 40 cycles, got 0 required 1", name);
      end
   endtask

   // Checks a full frame; the current sample must be position 0
   task automatic scan_frame(input string name, input logic [7:0] e3, input logic [7:0] e2,
                             input logic [7:0] e1, input logic [7:0] e0);
      logic [11:0] exp;
      for (int k = 0; k < 16; k++) begin
         if (k > 0) @(negedge clk);
         exp = exp_pins(k, e3, e2, e1, e0);
         tests++;
         if ({an, sseg} !== exp || frame_tick !== (k == 0)) begin
            fails++;
            $display("FAIL %s pos %0d: an=%b sseg=%h tick=%b, required an=%b sseg=%h tick=%b",
                     name, k, an, sseg, frame_tick, exp[11:8], exp[7:0], (k == 0));
         end
      end
   endtask

   task automatic do_load(input logic [15:0] h, input logic [3:0] dp,
                          input logic [3:0] bl, input logic lz);
      hex_in = h; dp_in = dp; blank_in = bl; lz_en = lz; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if (an !== 4'b1111 || sseg !== 8'hFF || frame_tick !== 1'b0) begin
         fails++;
         $display("FAIL reset: an=%b sseg=%h tick=%b, required an=1111 sseg=ff tick=0",
                  an, sseg, frame_tick);
      end
      reset = 1'b0;
      @(negedge clk);
      scan_frame("reset_dark0", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      @(negedge clk);
      scan_frame("reset_dark1", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
   endtask

   task automatic test_basic_scan();
      do_load(16'h1234, 4'h0, 4'h0, 1'b0);
      sync_frame("basic_sync");
      scan_frame("basic_scan", 8'hCF, 8'h92, 8'h86, 8'hCC);
   endtask

   task automatic test_frame_coherence();
      logic [11:0] exp;
      sync_frame("coh_sync");
      for (int k = 1; k < 16; k++) begin
         @(negedge clk);
         exp = exp_pins(k, 8'hCF, 8'h92, 8'h86, 8'hCC);
         tests++;
         if ({an, sseg} !== exp) begin
            fails++;
            $display("FAIL coh_old pos %0d: an=%b sseg=%h, required an=%b sseg=%h",
                     k, an, sseg, exp[11:8], exp[7:0]);
         end
         if (k == 3) begin hex_in = 16'hAAAA; dp_in = 4'h0; blank_in = 4'h0; lz_en = 1'b0; load = 1'b1; end
         if (k == 4) load = 1'b0;
         if (k == 5) begin hex_in = 16'h5555; load = 1'b1; end
         if (k == 6) load = 1'b0;
      end
      @(negedge clk);
      scan_frame("coh_new0", 8'hA4, 8'hA4, 8'hA4, 8'hA4);
      @(negedge clk);
      scan_frame("coh_new1", 8'hA4, 8'hA4, 8'hA4, 8'hA4);
   endtask

   task automatic test_leading_zero();
      do_load(16'h0070, 4'h0, 4'h0, 1'b1);
      sync_frame("lz_sync0");
      scan_frame("lz_0070", 8'hFF, 8'hFF, 8'h8F, 8'h81);
      do_load(16'h0000, 4'h0, 4'h0, 1'b1);
      sync_frame("lz_sync1");
      scan_frame("lz_0000", 8'hFF, 8'hFF, 8'hFF, 8'h81);
   endtask

   task automatic test_dp_blank();
      do_load(16'h1234, 4'b0100, 4'b0100, 1'b0);
      sync_frame("dpb_sync0");
      scan_frame("dp_blanked", 8'hCF, 8'hFF, 8'h86, 8'hCC);
      do_load(16'h1234, 4'b0100, 4'b0000, 1'b0);
      sync_frame("dpb_sync1");
      scan_frame("dp_lit", 8'hCF, 8'h12, 8'h86, 8'hCC);
   endtask

   // A load in the boundary cycle waits for the following boundary
   task automatic test_load_at_wrap();
      sync_frame("wrap_sync");
      for (int k = 1; k < 16; k++) @(negedge clk);
      hex_in = 16'h0008; dp_in = 4'h0; blank_in = 4'h0; lz_en = 1'b0; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      scan_frame("wrap_old", 8'hCF, 8'h12, 8'h86, 8'hCC);
      sync_frame("wrap_sync2");
      scan_frame("wrap_new", 8'h81, 8'h81, 8'h81, 8'h80);
   endtask

   task automatic test_reset_mid();
      sync_frame("rmid_sync");
      @(negedge clk);
      @(negedge clk);
      hex_in = 16'h8888; dp_in = 4'hF; blank_in = 4'h0; lz_en = 1'b0; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      tests++;
      if (an !== 4'b1111 || sseg !== 8'hFF || frame_tick !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid: an=%b sseg=%h tick=%b, required an=1111 sseg=ff tick=0",
                  an, sseg, frame_tick);
      end
      @(negedge clk);
      reset = 1'b0;
      sync_frame("rmid_sync2");
      scan_frame("rmid_dark0", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      sync_frame("rmid_sync3");
      scan_frame("rmid_dark1", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
   endtask

   initial begin
      test_reset();
      test_basic_scan();
      test_frame_coherence();
      test_leading_zero();
      test_dp_blank();
      test_load_at_wrap();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
